// File: rtl/iob_wb_decoder.sv
// rtl/iob_wb_decoder.sv - Wishbone two-slave address decoder with bus watchdog and error log
module iob_wb_decoder #(
    parameter int unsigned          ADDR_W  = 32,
    parameter int unsigned          DATA_W  = 32,
    parameter logic [ADDR_W-1:0]    S0_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]    S0_MASK = 32'hFFFF_F000,
    parameter logic [ADDR_W-1:0]    S1_BASE = 32'h0000_1000,
    parameter logic [ADDR_W-1:0]    S1_MASK = 32'hFFFF_F000,
    parameter int unsigned          TIMEOUT = 200
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [ADDR_W-1:0]       wb_addr_i,
    input  logic [DATA_W-1:0]       wb_data_i,
    input  logic [DATA_W/8-1:0]     wb_select_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic [DATA_W-1:0]       wb_data_o,
    output logic                    wb_ack_o,
    output logic                    wb_error_o,
    output logic [ADDR_W-1:0]       s0_addr_o,
    output logic [ADDR_W-1:0]       s1_addr_o,
    output logic [DATA_W-1:0]       s0_data_o,
    output logic [DATA_W-1:0]       s1_data_o,
    output logic [DATA_W/8-1:0]     s0_select_o,
    output logic [DATA_W/8-1:0]     s1_select_o,
    output logic                    s0_we_o,
    output logic                    s1_we_o,
    output logic                    s0_cyc_o,
    output logic                    s0_stb_o,
    output logic                    s1_cyc_o,
    output logic                    s1_stb_o,
    input  logic [DATA_W-1:0]       s0_data_i,
    input  logic                    s0_ack_i,
    input  logic                    s0_err_i,
    input  logic [DATA_W-1:0]       s1_data_i,
    input  logic                    s1_ack_i,
    input  logic                    s1_err_i,
    input  logic                    err_clr_i,
    output logic [7:0]              err_cnt_o,
    output logic [ADDR_W-1:0]       last_err_addr_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR, DRAIN} state_t;
    typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_NONE} sel_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t             state;
    sel_t               sel;
    logic [7:0]         tmo_cnt;

    logic               req;
    logic               hit0;
    logic               hit1;
    logic               act;
    logic               tmo;
    logic               s_ack;
    logic               s_err;
    logic [DATA_W-1:0]  s_data;

    assign req  = wb_cyc_i & wb_stb_i;
    assign hit0 = (wb_addr_i & S0_MASK) == S0_BASE;
    assign hit1 = (wb_addr_i & S1_MASK) == S1_BASE;
    assign act  = (state == ACTIVE) & wb_cyc_i;
    assign tmo  = tmo_cnt == TMO_LAST;

    always_comb begin
        s_ack  = 1'b0;
        s_err  = 1'b0;
        s_data = '0;
        case (sel)
            SEL_S0: begin
                s_ack  = s0_ack_i;
                s_err  = s0_err_i;
                s_data = s0_data_i;
            end
            SEL_S1: begin
                s_ack  = s1_ack_i;
                s_err  = s1_err_i;
                s_data = s1_data_i;
            end
            default: ;
        endcase
    end

    // Slave error beats ack; a timeout only fires when the slave is silent.
    assign wb_ack_o   = act & ~s_err & s_ack;
    assign wb_error_o = (state == ERR) | (act & s_err) | (act & ~s_ack & tmo);
    assign wb_data_o  = wb_ack_o ? s_data : '0;

    assign s0_cyc_o = act & (sel == SEL_S0);
    assign s0_stb_o = s0_cyc_o;
    assign s1_cyc_o = act & (sel == SEL_S1);
    assign s1_stb_o = s1_cyc_o;

    assign s0_addr_o   = wb_addr_i;
    assign s1_addr_o   = wb_addr_i;
    assign s0_data_o   = wb_data_i;
    assign s1_data_o   = wb_data_i;
    assign s0_select_o = wb_select_i;
    assign s1_select_o = wb_select_i;
    assign s0_we_o     = wb_we_i;
    assign s1_we_o     = wb_we_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            sel             <= SEL_NONE;
            tmo_cnt         <= '0;
            err_cnt_o       <= '0;
            last_err_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        tmo_cnt <= '0;
                        if (hit1) begin
                            sel   <= SEL_S1;
                            state <= ACTIVE;
                        end else if (hit0) begin
                            sel   <= SEL_S0;
                            state <= ACTIVE;
                        end else begin
                            sel   <= SEL_NONE;
                            state <= ERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else if (s_err || s_ack || tmo) begin
                        state <= DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ERR:     state <= DRAIN;
                default: state <= IDLE;
            endcase

            if (err_clr_i) begin
                err_cnt_o <= '0;
            end else if (wb_error_o && err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
            if (wb_error_o) begin
                last_err_addr_o <= wb_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_iob_wb_decoder.sv
// tb/tb_iob_wb_decoder.sv - directed bench with per-cycle expectation model for iob_wb_decoder
module tb_iob_wb_decoder;

    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [31:0] wb_addr_i, wb_data_i;
    logic [3:0]  wb_select_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o, wb_error_o;
    logic [31:0] s0_addr_o, s1_addr_o, s0_data_o, s1_data_o;
    logic [3:0]  s0_select_o, s1_select_o;
    logic        s0_we_o, s1_we_o, s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o;
    logic [31:0] s0_data_i, s1_data_i;
    logic        s0_ack_i, s0_err_i, s1_ack_i, s1_err_i;
    logic        err_clr_i;
    logic [7:0]  err_cnt_o;
    logic [31:0] last_err_addr_o;

    always #5 clk = ~clk;

    iob_wb_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_select_i(wb_select_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_error_o(wb_error_o),
        .s0_addr_o(s0_addr_o), .s1_addr_o(s1_addr_o),
        .s0_data_o(s0_data_o), .s1_data_o(s1_data_o),
        .s0_select_o(s0_select_o), .s1_select_o(s1_select_o),
        .s0_we_o(s0_we_o), .s1_we_o(s1_we_o),
        .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o),
        .s0_data_i(s0_data_i), .s0_ack_i(s0_ack_i), .s0_err_i(s0_err_i),
        .s1_data_i(s1_data_i), .s1_ack_i(s1_ack_i), .s1_err_i(s1_err_i),
        .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o), .last_err_addr_o(last_err_addr_o)
    );

    int passed = 0;
    int total  = 0;

    // Expected outputs for the current cycle, plus the error log model.
    logic        chk_en = 1'b0;
    logic        chk_stb;
    logic        exp_ack, exp_err, exp_s0, exp_s1;
    logic [31:0] exp_data;
    int          m_cnt;
    logic [31:0] m_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wb_ack", 32'(wb_ack_o), 32'(exp_ack));
            check("wb_error", 32'(wb_error_o), 32'(exp_err));
            check("wb_data", wb_data_o, exp_data);
            if (chk_stb) begin
                check("s0_cyc", 32'(s0_cyc_o), 32'(exp_s0));
                check("s0_stb", 32'(s0_stb_o), 32'(exp_s0));
                check("s1_cyc", 32'(s1_cyc_o), 32'(exp_s1));
                check("s1_stb", 32'(s1_stb_o), 32'(exp_s1));
            end
            check("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
            check("last_err_addr", last_err_addr_o, m_last);
            check("s1_addr", s1_addr_o, wb_addr_i);
            check("s0_data", s0_data_o, wb_data_i);
            check("s1_select", 32'(s1_select_o), 32'(wb_select_i));
            check("s1_we", 32'(s1_we_o), 32'(wb_we_i));
        end
    end

    task automatic clear_exp();
        exp_ack = 1'b0; exp_err = 1'b0; exp_data = '0;
        exp_s0 = 1'b0; exp_s1 = 1'b0; chk_stb = 1'b1;
    endtask

    // Advance one clock; the error log model moves on the same edge as the DUT.
    task automatic tick();
        @(posedge clk);
        if (!rst_n_i) begin
            m_cnt = 0; m_last = '0;
        end else begin
            if (err_clr_i) m_cnt = 0;
            else if (exp_err && m_cnt != 255) m_cnt++;
            if (exp_err) m_last = wb_addr_i;
        end
        #1;
    endtask

    // tgt: 0=s0 1=s1 2=unmapped; kind: 0=ack 1=err 2=ack+err 3=silent; d: cycles after first strobe
    task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] sl,
                       input int tgt, input int kind, input int d, input logic [31:0] rd);
        int n;
        wb_addr_i = a; wb_we_i = we; wb_select_i = sl; wb_data_i = 32'hA5A5_0000 ^ a;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        s0_data_i = rd; s1_data_i = rd;
        clear_exp(); tick();
        if (tgt == 2) begin
            clear_exp(); exp_err = 1'b1; tick();
            clear_exp(); tick();
        end else begin
            n = (kind == 3) ? TIMEOUT : d + 1;
            for (int c = 1; c <= n; c++) begin
                clear_exp(); exp_s0 = (tgt == 0); exp_s1 = (tgt == 1);
                if (c == n) begin
                    if (kind == 3) begin
                        exp_err = 1'b1; chk_stb = 1'b0;
                    end else begin
                        if (kind == 0) begin exp_ack = 1'b1; exp_data = rd; end
                        else exp_err = 1'b1;
                        if (tgt == 0) begin
                            s0_ack_i = (kind != 1); s0_err_i = (kind != 0);
                        end else begin
                            s1_ack_i = (kind != 1); s1_err_i = (kind != 0);
                        end
                    end
                end
                tick();
            end
            s0_ack_i = 1'b0; s0_err_i = 1'b0; s1_ack_i = 1'b0; s1_err_i = 1'b0;
            clear_exp(); tick();
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        clear_exp(); tick();
    endtask

    initial begin
        rst_n_i = 1'b0; err_clr_i = 1'b0;
        wb_addr_i = '0; wb_data_i = '0; wb_select_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        s0_data_i = '0; s1_data_i = '0;
        s0_ack_i = 1'b0; s0_err_i = 1'b0; s1_ack_i = 1'b0; s1_err_i = 1'b0;
        m_cnt = 0; m_last = '0;
        clear_exp();
        tick();
        chk_en = 1'b1;
        tick();
        rst_n_i = 1'b1;
        tick();
        check("reset_err_cnt", 32'(err_cnt_o), 32'd0);

        txn(32'h0000_0004, 1'b0, 4'hF, 0, 0, 2, 32'hDEAD_BEEF);
        txn(32'h0000_1010, 1'b1, 4'b0011, 1, 0, 1, 32'h0000_0000);
        check("write_err_cnt_unchanged", 32'(err_cnt_o), 32'd0);

        txn(32'h0000_8000, 1'b0, 4'hF, 2, 0, 0, 32'h0);
        check("unmapped_err_cnt", 32'(err_cnt_o), 32'd1);
        check("unmapped_last_addr", last_err_addr_o, 32'h0000_8000);

        txn(32'h0000_0100, 1'b0, 4'hF, 0, 3, 0, 32'h1111_2222);
        check("timeout_err_cnt", 32'(err_cnt_o), 32'd2);
        check("timeout_last_addr", last_err_addr_o, 32'h0000_0100);

        txn(32'h0000_1004, 1'b0, 4'hF, 1, 2, 0, 32'h3333_4444);
        check("ack_err_err_cnt", 32'(err_cnt_o), 32'd3);

        txn(32'h0000_0008, 1'b0, 4'hF, 0, 1, 3, 32'h5555_6666);
        check("slave_err_cnt", 32'(err_cnt_o), 32'd4);

        err_clr_i = 1'b1; clear_exp(); tick(); err_clr_i = 1'b0;
        check("clear_err_cnt", 32'(err_cnt_o), 32'd0);
        for (int i = 0; i < 256; i++)
            txn(32'h0001_0000 + 32'(i), 1'b0, 4'hF, 2, 0, 0, 32'h0);
        check("saturated_err_cnt", 32'(err_cnt_o), 32'd255);
        check("saturated_last_addr", last_err_addr_o, 32'h0001_00FF);

        err_clr_i = 1'b1;
        txn(32'h0000_9000, 1'b0, 4'hF, 2, 0, 0, 32'h0);
        err_clr_i = 1'b0;
        check("clr_with_error_cnt", 32'(err_cnt_o), 32'd0);

        txn(32'h0000_A000, 1'b0, 4'hF, 2, 0, 0, 32'h0);
        check("pre_reset_err_cnt", 32'(err_cnt_o), 32'd1);

        // Reset lands on the second ACTIVE cycle of an s0 access.
        wb_addr_i = 32'h0000_0010; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        s0_data_i = 32'h7777_8888;
        clear_exp(); tick();
        clear_exp(); exp_s0 = 1'b1; tick();
        rst_n_i = 1'b0;
        clear_exp(); exp_s0 = 1'b1; tick();
        rst_n_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        clear_exp(); tick();
        check("post_reset_err_cnt", 32'(err_cnt_o), 32'd0);
        check("post_reset_last_addr", last_err_addr_o, 32'h0);

        txn(32'h0000_0008, 1'b0, 4'hF, 0, 0, 0, 32'h600D_F00D);
        txn(32'h0000_1FFC, 1'b0, 4'hF, 1, 0, 4, 32'hCAFE_0001);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iob_wb_decoder.md
# iob_wb_decoder

Wishbone address decoder and bus watchdog placed directly downstream of the IOb-to-Wishbone bridge. It routes each bridge cycle to one of two Wishbone slaves, typically the ethmac register slave and a second peripheral. It answers unmapped addresses and unresponsive slaves with a one-cycle `wb_error_o`, so a CPU request can never hang. It also keeps a saturating error counter and records the address of the most recent error for debug.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `S0_BASE` / `S0_MASK`, 32'h0000_0000 / 32'hFFFF_F000, slave 0 hits when `(addr & S0_MASK) == S0_BASE`
- `S1_BASE` / `S1_MASK`, 32'h0000_1000 / 32'hFFFF_F000, slave 1 match, same rule
- `TIMEOUT`, 200, number of ACTIVE cycles without a response before the block forces an error (2..255)

Ports:
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset, synchronous, active-low
- `wb_addr_i`, `wb_data_i`, `wb_select_i`, `wb_we_i`, `wb_cyc_i`, `wb_stb_i`  in  ADDR_W/DATA_W/DATA_W/8/1/1/1  master side (from bridge)
- `wb_data_o`, `wb_ack_o`, `wb_error_o`  out  DATA_W/1/1  master side response
- `s0_addr_o`, `s1_addr_o`  out  ADDR_W  slave address (copy of `wb_addr_i`)
- `s0_data_o`, `s1_data_o`, `s0_select_o`, `s1_select_o`, `s0_we_o`, `s1_we_o`  out  DATA_W/DATA_W/8/1  write data, select and write enable (copies)
- `s0_cyc_o`, `s0_stb_o`, `s1_cyc_o`, `s1_stb_o`  out  1  slave strobes, gated by the decoded target
- `s0_data_i`, `s0_ack_i`, `s0_err_i`, `s1_data_i`, `s1_ack_i`, `s1_err_i`  in  DATA_W/1/1  slave responses
- `err_clr_i`  in  1  clears `err_cnt_o`
- `err_cnt_o`  out  8  saturating error count
- `last_err_addr_o`  out  ADDR_W  address of the most recent error

## Operation
- FSM states: IDLE, ACTIVE, ERR, DRAIN. A 2-bit `sel` register holds the target: S0, S1 or NONE.
- IDLE: when `wb_cyc_i & wb_stb_i` is high, decode the address.
  - Slave 1 match has priority over slave 0.
  - On a slave hit, latch `sel`, clear the timeout counter and go to ACTIVE.
  - On no hit, go to ERR.
- ACTIVE: `sN_cyc_o = sN_stb_o = wb_cyc_i` for the selected slave; the other slave's strobes stay 0.
  - `sN_err_i`: `wb_error_o = 1`, go to DRAIN. Error has priority over a simultaneous ack.
  - `sN_ack_i` (no error): `wb_ack_o = 1`, `wb_data_o = sN_data_i`, go to DRAIN.
  - No response: increment the counter. On the cycle the counter equals `TIMEOUT-1`, assert `wb_error_o`, drop the slave strobes and go to DRAIN. An ack arriving on that same cycle wins and is treated as a normal ack.
  - `wb_cyc_i` low: abort. Strobes drop the same cycle, no ack or error is generated, next state IDLE.
- ERR: `wb_error_o = 1` for exactly one cycle, then DRAIN.
- DRAIN: exactly one cycle; `wb_stb_i` is ignored, then IDLE. This absorbs the bridge holding `stb` for one cycle after ack.
- `wb_data_o` is 0 except during an ack cycle.
- Error bookkeeping, on every `wb_error_o` cycle:
  - `err_cnt_o` increments, saturating at 255.
  - `last_err_addr_o` takes `wb_addr_i`.
  - `err_clr_i` has priority: `err_cnt_o` goes to 0 and the concurrent increment is dropped.

## Timing
- Reset (`rst_n_i = 0` at an edge):
  - State IDLE, `sel` = NONE, timeout counter 0.
  - `err_cnt_o` 0, `last_err_addr_o` 0.
  - All `sN_cyc_o`/`sN_stb_o`, `wb_ack_o`, `wb_error_o` are 0 and `wb_data_o` is 0 from the following cycle.
- Reset in mid-transaction aborts without any response.
- A request seen in IDLE at cycle 0 puts the slave strobe high from cycle 1.
- A slave ack at cycle k is passed through combinationally, so `wb_ack_o` is high at cycle k. DRAIN is at k+1; the earliest new accept is IDLE at k+2.
- Unmapped address: `wb_error_o` at cycle 1, IDLE at cycle 3.
- Timeout: `wb_error_o` on the `TIMEOUT`-th ACTIVE cycle, i.e. cycle `TIMEOUT` for a request at cycle 0.
- `wb_ack_o` and `wb_error_o` are never high together and are each at most one cycle per transaction.

## Test plan
- Read 0x0000_0004 with s0 acking 2 cycles after its strobe and returning 0xDEADBEEF:
  - `s0_stb_o` is high at cycle 1 and `s1_stb_o` stays 0.
  - `wb_ack_o` and `wb_data_o = 0xDEADBEEF` at cycle 3.
  - Exactly one slave access, despite `stb` staying high in DRAIN.
- Write 0x0000_1010 with strobe 4'b0011: `s1_we_o = 1`, `s1_select_o = 0011`, s1 acks, a single `wb_ack_o`, `err_cnt_o` unchanged.
- Access to 0x0000_8000: `wb_error_o` at cycle 1, no slave strobe, `err_cnt_o` = 1, `last_err_addr_o` = 0x0000_8000.
- s0 never responds with `TIMEOUT` = 200: `wb_error_o` at cycle 200, `s0_stb_o` low from cycle 201, `err_cnt_o` increments.
- s1 asserts ack and err together: only `wb_error_o`. 256 forced errors give `err_cnt_o` = 255; `err_clr_i` together with an error gives 0.
- `rst_n_i` low at cycle 2 of an ACTIVE access: all outputs 0 next cycle, no ack, and the next request is served normally.
